// File: rtl/solve_sequencer.sv
// Hands RREF jobs to an enumerator, tracks the minimum solution popcount
// per job and keeps a running total. Optional watchdog: SOLVE_SEQUENCER_TIMEOUT_EN.
module solve_sequencer #(
  parameter int ROWS           = 4,
  parameter int COLS           = 5,
  parameter int SUM_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [ROWS-1:0][COLS-1:0]     job_rref,
  output logic                          enum_start,
  output logic [ROWS-1:0][COLS-1:0]     enum_rref,
  input  logic                          sol_tvalid,
  input  logic [7:0]                    sol_tdata,
  input  logic                          sol_tlast,
  output logic                          sol_tready,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(COLS):0]         res_min,
  output logic                          res_err,
  output logic [SUM_W-1:0]              total
);

  localparam int MW = $clog2(COLS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    COLLECT,
    REPORT
  } state_t;

  state_t        state;
  logic [MW-1:0] min;
  logic [MW-1:0] pop;
  logic [MW-1:0] new_min;
  logic          beat;

`ifdef SOLVE_SEQUENCER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
`else
  assign res_err = 1'b0;
`endif

  // popcount of the variable bits of the beat and the candidate minimum
  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < COLS - 1) pop = pop + MW'(sol_tdata[i]);
    end
    beat    = sol_tvalid && sol_tready;
    new_min = (pop < min) ? pop : min;
  end

  // job sequencing FSM with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      job_ready  <= 1'b1;
      enum_start <= 1'b0;
      sol_tready <= 1'b0;
      res_valid  <= 1'b0;
      res_min    <= '0;
      total      <= '0;
      enum_rref  <= '0;
      min        <= '1;
`ifdef SOLVE_SEQUENCER_TIMEOUT_EN
      wd         <= '0;
      res_err    <= 1'b0;
`endif
    end else begin
      enum_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (job_valid) begin
            enum_rref  <= job_rref;
            job_ready  <= 1'b0;
            enum_start <= 1'b1;
            min        <= '1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          sol_tready <= 1'b1;
`ifdef SOLVE_SEQUENCER_TIMEOUT_EN
          wd         <= '0;
`endif
          state      <= COLLECT;
        end
        COLLECT: begin
          if (beat) begin
            min <= new_min;
`ifdef SOLVE_SEQUENCER_TIMEOUT_EN
            wd  <= '0;
`endif
            if (sol_tlast) begin
              sol_tready <= 1'b0;
              res_valid  <= 1'b1;
              res_min    <= new_min;
              state      <= REPORT;
            end
          end
`ifdef SOLVE_SEQUENCER_TIMEOUT_EN
          else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            sol_tready <= 1'b0;
            res_valid  <= 1'b1;
            res_min    <= '1;
            res_err    <= 1'b1;
            state      <= REPORT;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        REPORT: begin
          if (res_ready) begin
            if (!res_err) total <= total + SUM_W'(res_min);
`ifdef SOLVE_SEQUENCER_TIMEOUT_EN
            res_err   <= 1'b0;
`endif
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_solve_sequencer.sv
// Testbench for solve_sequencer: table vectors, corner sequences and
// randomized jobs checked against a popcount-minimum reference model.
module tb_solve_sequencer;

  logic             clk = 0;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  logic [3:0][4:0]  job_rref;
  logic             enum_start;
  logic [3:0][4:0]  enum_rref;
  logic             sol_tvalid;
  logic [7:0]       sol_tdata;
  logic             sol_tlast;
  logic             sol_tready;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_min;
  logic             res_err;
  logic [31:0]      total;

  solve_sequencer #(
    .ROWS(4), .COLS(5), .SUM_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_rref(job_rref),
    .enum_start(enum_start), .enum_rref(enum_rref),
    .sol_tvalid(sol_tvalid), .sol_tdata(sol_tdata),
    .sol_tlast(sol_tlast), .sol_tready(sol_tready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_min(res_min), .res_err(res_err), .total(total)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          starts = 0;
  logic [31:0] model_total = 0;
  logic [7:0]  bq[$];

  always @(negedge clk) if (enum_start) starts++;

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [3:0] exp_min;
    int         hold;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // minimum popcount over the variable bits [3:0]; 15 if no beats
  function automatic logic [3:0] ref_min();
    int m = 15;
    foreach (bq[i]) begin
      int c = $countones(bq[i] & 8'h0F);
      if (c < m) m = c;
    end
    return 4'(m);
  endfunction

  task automatic do_job(input logic [19:0] rref, input logic [3:0] exp,
                        input int max_gap, input int hold);
    check("idle_job_ready", job_ready, 1);
    job_valid = 1; job_rref = rref;
    tick();
    job_valid = 0; job_rref = 20'($urandom);
    check("launch_start", enum_start, 1);
    check("launch_rref", enum_rref, rref);
    check("launch_tready", sol_tready, 0);
    tick();
    check("collect_start_low", enum_start, 0);
    check("collect_tready", sol_tready, 1);
    check("collect_rref", enum_rref, rref);
    foreach (bq[i]) begin
      int g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (g) begin
        sol_tvalid = 0; job_valid = 1'($urandom);
        tick();
        check("collect_job_ready", job_ready, 0);
      end
      job_valid = 0;
      sol_tvalid = 1; sol_tdata = bq[i];
      sol_tlast = (i == bq.size() - 1);
      tick();
    end
    sol_tvalid = 0; sol_tlast = 0;
    check("report_valid", res_valid, 1);
    check("report_min", res_min, exp);
    check("report_err", res_err, 0);
    check("report_tready", sol_tready, 0);
    repeat (hold) begin
      job_valid = 1; sol_tvalid = 1; sol_tdata = 0; sol_tlast = 1;
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_min", res_min, exp);
      check("hold_job_ready", job_ready, 0);
    end
    job_valid = 0; sol_tvalid = 0; sol_tlast = 0;
    res_ready = 1;
    tick();
    res_ready = 0;
    model_total = model_total + 32'(exp);
    check("done_valid", res_valid, 0);
    check("done_job_ready", job_ready, 1);
    check("done_total", total, model_total);
  endtask

  initial begin
    vec_t tbl[5];
    int   s0;

    tbl[0] = '{3, 8'b1011, 8'b0001, 8'b0110, 4'd1, 0};
    tbl[1] = '{1, 8'h00, 8'h00, 8'h00, 4'd0, 0};
    tbl[2] = '{2, 8'hF0, 8'h0F, 8'h00, 4'd0, 0};
    tbl[3] = '{2, 8'h0F, 8'h07, 8'h00, 4'd3, 10};
    tbl[4] = '{1, 8'hFF, 8'h00, 8'h00, 4'd4, 2};

    rst = 1; job_valid = 0; job_rref = 0; sol_tvalid = 0;
    sol_tdata = 0; sol_tlast = 0; res_ready = 0;
    repeat (2) tick();
    check("rst_job_ready", job_ready, 1);
    check("rst_enum_start", enum_start, 0);
    check("rst_tready", sol_tready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_err", res_err, 0);
    check("rst_res_min", res_min, 0);
    check("rst_total", total, 0);
    check("rst_enum_rref", enum_rref, 0);
    rst = 0;
    tick();

    // two jobs, minima 3 then 2
    s0 = starts;
    bq = '{8'h07};
    do_job(20'h12345, 4'd3, 0, 0);
    bq = '{8'h0C, 8'h0E};
    do_job(20'h0ABCD, 4'd2, 0, 0);
    check("two_jobs_total", total, 5);
    check("two_jobs_starts", starts - s0, 2);

    // table vectors
    for (int k = 0; k < 5; k++) begin
      bq.delete();
      bq.push_back(tbl[k].b0);
      if (tbl[k].n > 1) bq.push_back(tbl[k].b1);
      if (tbl[k].n > 2) bq.push_back(tbl[k].b2);
      do_job(20'($urandom), tbl[k].exp_min, 0, tbl[k].hold);
    end

    // no beats in COLLECT
    job_valid = 1; job_rref = 20'h55555;
    tick();
    job_valid = 0;
    tick();
    check("nobeat_tready", sol_tready, 1);
`ifdef SOLVE_SEQUENCER_TIMEOUT_EN
    repeat (15) tick();
    check("wd_not_yet", res_valid, 0);
    tick();
    check("wd_valid", res_valid, 1);
    check("wd_err", res_err, 1);
    check("wd_min", res_min, 4'hF);
    res_ready = 1;
    tick();
    res_ready = 0;
    check("wd_total", total, model_total);
    check("wd_job_ready", job_ready, 1);
`else
    repeat (40) tick();
    check("wait_valid", res_valid, 0);
    check("wait_tready", sol_tready, 1);
    sol_tvalid = 1; sol_tdata = 8'h03; sol_tlast = 1;
    tick();
    sol_tvalid = 0; sol_tlast = 0;
    check("wait_min", res_min, 2);
    check("wait_err", res_err, 0);
    res_ready = 1;
    tick();
    res_ready = 0;
    model_total = model_total + 2;
    check("wait_total", total, model_total);
`endif

    // reset mid-COLLECT after two beats
    job_valid = 1; job_rref = 20'h0F0F0;
    tick();
    job_valid = 0;
    tick();
    sol_tvalid = 1; sol_tdata = 8'h01;
    tick();
    sol_tdata = 8'h03;
    tick();
    sol_tvalid = 0;
    #2 rst = 1;
    #1;
    check("midrst_job_ready", job_ready, 1);
    check("midrst_tready", sol_tready, 0);
    check("midrst_total", total, 0);
    check("midrst_rref", enum_rref, 0);
    #1 rst = 0;
    tick();
    model_total = 0;
    bq = '{8'h07, 8'h0F};
    do_job(20'h00FFF, 4'd3, 0, 0);

    // randomized jobs against the reference model
    for (int j = 0; j < 30; j++) begin
      int n = $urandom_range(1, 5);
      bq.delete();
      repeat (n) bq.push_back(8'($urandom));
      do_job(20'($urandom), ref_min(), 3, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/solve_sequencer.md
SOLVE_SEQUENCER -- requirements
Module: solve_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ROWS, 4, RREF row count.
- COLS, 5, RREF column count; variables = COLS-1; column 0 = RHS.
- SUM_W, 32, running-total width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with SOLVE_SEQUENCER_TIMEOUT_EN.
REQ-002 Ports, one per line (name, direction, width, meaning); single clock; reset asynchronous, active-high:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- job_valid  in  1  RREF job offered.
- job_ready  out  1  job accepted when job_valid && job_ready.
- job_rref  in  COLS x ROWS  RREF matrix for one machine.
- enum_start  out  1  one-cycle start pulse to the enumerator.
- enum_rref  out  COLS x ROWS  registered matrix held stable to the enumerator.
- sol_tvalid  in  1  solution beat valid.
- sol_tdata  in  8  solution vector in bits [COLS-2:0].
- sol_tlast  in  1  final solution.
- sol_tready  out  1  beat accepted when sol_tvalid && sol_tready.
- res_valid  out  1  per-job result available.
- res_ready  in  1  result consumed.
- res_min  out  clog2(COLS)+1  minimum solution popcount for the job.
- res_err  out  1  job aborted by watchdog.
- total  out  SUM_W  sum of res_min over all non-error jobs.

Function
REQ-003 FSM states: IDLE, LAUNCH, COLLECT, REPORT.
REQ-004 IDLE: job_ready=1; on acceptance, latch job_rref into enum_rref and go to LAUNCH.
REQ-005 LAUNCH lasts exactly one cycle: enum_start=1, min register preset to all-ones, then go to COLLECT.
REQ-006 enum_start is 0 in every state other than LAUNCH.
REQ-007 COLLECT: sol_tready=1; sol_tready is 0 in all other states.
REQ-008 Each accepted beat: p = popcount(sol_tdata[COLS-2:0]); min <= (p < min) ? p : min; bits above COLS-2 ignored.
REQ-009 Beat accepted with sol_tlast=1: update min with that beat, then go to REPORT next cycle.
REQ-010 REPORT: res_valid=1, res_min=min, res_err=0 unless aborted; hold stable until res_ready.
REQ-011 REPORT with res_ready: total <= total + res_min (modulo 2^SUM_W, skipped if res_err); go to IDLE; job_ready is 1 in that next cycle.
REQ-012 Latency: job acceptance -> enum_start = 1 cycle; last beat -> res_valid = 1 cycle.
REQ-013 sol_tvalid while not in COLLECT is ignored; no state change.
REQ-014 job_valid while not in IDLE is ignored; job_ready=0.
REQ-015 enum_rref changes only on job acceptance.

Reset
REQ-016 rst asserted at any time, including mid-COLLECT, forces IDLE immediately.
REQ-017 Reset values: job_ready=1 (IDLE), enum_start=0, sol_tready=0, res_valid=0, res_err=0, res_min=0, total=0, enum_rref=0, min=all-ones, watchdog=0.

Configuration
REQ-018 Macro SOLVE_SEQUENCER_TIMEOUT_EN defined: watchdog counts COLLECT cycles without an accepted beat and clears on each accepted beat.
REQ-019 Watchdog reaching TIMEOUT_CYCLES -> REPORT with res_err=1, res_min=all-ones; total unchanged.
REQ-020 Macro undefined: no watchdog logic is built; res_err is tied to 0; COLLECT waits indefinitely.

Verification
REQ-021 Beats 0b1011, 0b0001, 0b0110 (last) -> res_min=1; total=1 after res_ready.
REQ-022 Two jobs with minima 3 then 2 -> total=5; enum_start pulses exactly twice, each one cycle.
REQ-023 res_ready held low 10 cycles in REPORT -> res_valid, res_min stable; job_ready=0; next job_valid ignored.
REQ-024 Single beat 0b0000 with tlast -> res_min=0, res_valid on the cycle after the beat.
REQ-025 rst pulsed mid-COLLECT after 2 beats -> IDLE next cycle; total=0; a following job reports its own fresh minimum.
REQ-026 TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no beats -> res_err=1 after 16 COLLECT cycles; total unchanged.
